// File: rtl/sar_adc_ctrl_pkg.sv
// Shared types and constants for the SAR ADC controller and its synchronizer.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        BIT,
        DONE
    } state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Digital/analog boundary signals of the SAR controller; slave is the controller side.
interface sar_adc_ctrl_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic             abort;
    logic             cmp_in;
    logic             sample_o;
    logic [NBITS-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] result;

    modport master (
        output start, abort, cmp_in,
        input  sample_o, dac_code, busy, done, result
    );

    modport slave (
        input  start, abort, cmp_in,
        output sample_o, dac_code, busy, done, result
    );
endinterface

// File: rtl/sar_adc_ctrl_sync_2ff.sv
// Generic flop-chain synchronizer for the asynchronous comparator output.
module sync_2ff
    import sar_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: track phase, one trial per bit, one-cycle done.
//
// state  | meaning
// IDLE   | waiting for start, DAC parked at 0
// SAMPLE | track switch closed for SAMPLE_CYCLES
// BIT    | trial code on DAC for T_BIT cycles, bit idx decided on the last one
// DONE   | one cycle: result updated, done pulsed, start may chain a new conversion
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sar_adc_ctrl_if.slave        bus
);

    localparam int T_BIT = SETTLE_CYCLES + SYNC_STAGES;
    localparam int CNT_W = max_int(1, $clog2(max_int(SAMPLE_CYCLES, T_BIT)));
    localparam int IDX_W = max_int(1, $clog2(NBITS));

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD    = CNT_W'(T_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(NBITS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NBITS-1:0]   code_q, code_d;
    logic [NBITS-1:0]   result_q, result_d;
    logic [NBITS-1:0]   trial;
    logic               cmp_sync;
    logic               sample_o;
    logic               busy;
    logic               done;
    logic [NBITS-1:0]   dac_code;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.cmp_in),
        .q   (cmp_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        code_d   = code_q;
        result_d = result_q;
        sample_o = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        dac_code = '0;
        trial    = code_q;
        trial[idx_q] = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                end
            end
            SAMPLE: begin
                sample_o = 1'b1;
                busy     = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = BIT;
                    cnt_d   = BIT_LOAD;
                    idx_d   = IDX_MSB;
                    code_d  = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BIT: begin
                busy     = 1'b1;
                dac_code = trial;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    // Only the synchronized comparator decides the trial bit.
                    code_d         = trial;
                    code_d[idx_q]  = cmp_sync;
                    if (idx_q == '0) begin
                        state_d  = DONE;
                        result_d = code_d;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        cnt_d = BIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                done     = 1'b1;
                dac_code = code_q;
                if (bus.start && !bus.abort) begin
                    state_d = SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign bus.sample_o = sample_o;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.dac_code = dac_code;
    assign bus.result   = result_q;

endmodule
